rat_checkpoint_store: RTL and testbench

- Responder side of the branch-buffer checkpoint protocol.
- On copy_rat, snapshots the live rename table (RAT) into slot copy_idx.
- On paste_rat, returns the saved mapping from slot paste_idx one cycle later and squashes that slot plus every younger slot.
- Sits between the branch buffer and the RAT/free-list restore mux in the rename stage.

---
 rtl/rat_checkpoint_store.sv | 157 +++++++++++++++
 tb/tb_rat_checkpoint_store.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rat_checkpoint_store.sv
// Branch checkpoint store: snapshots the RAT on copy, restores and squashes younger slots on paste.
// Optional free-list head save/restore is enabled with `define CKPT_FREELIST_EN.
module rat_checkpoint_store #(
  parameter int NUM_ARCH = 32,
  parameter int PTAG_W   = 6,
  parameter int NUM_CKPT = 32,
  parameter int IDX_W    = 5
`ifdef CKPT_FREELIST_EN
  ,
  parameter int FL_PTR_W = 6
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         copy_rat,
  input  logic [IDX_W-1:0]             copy_idx,
  input  logic [NUM_ARCH*PTAG_W-1:0]   rat_map_in,
  input  logic                         paste_rat,
  input  logic [IDX_W-1:0]             paste_idx,
  input  logic                         release_rat,
  input  logic [IDX_W-1:0]             release_idx,
`ifdef CKPT_FREELIST_EN
  input  logic [FL_PTR_W-1:0]          fl_head_in,
  output logic [FL_PTR_W-1:0]          restore_fl_head,
`endif
  output logic                         restore_valid,
  output logic [NUM_ARCH*PTAG_W-1:0]   restore_map,
  output logic                         restore_err,
  output logic                         ckpt_overwrite,
  output logic [NUM_CKPT-1:0]          ckpt_valid,
  output logic [IDX_W-1:0]             youngest_idx
);

  localparam int MAP_W = NUM_ARCH * PTAG_W;

  logic [MAP_W-1:0]    slot_q [NUM_CKPT];
`ifdef CKPT_FREELIST_EN
  logic [FL_PTR_W-1:0] fl_q [NUM_CKPT];
  logic [FL_PTR_W-1:0] restore_fl_q, restore_fl_d;
`endif

  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]    youngest_q, youngest_d;
  logic [MAP_W-1:0]    restore_map_q, restore_map_d;
  logic                restore_valid_q, restore_valid_d;
  logic                restore_err_q, restore_err_d;
  logic                overwrite_q, overwrite_d;

  logic                paste_ok;
  logic                copy_ok;
  logic [NUM_CKPT-1:0] squash_mask;

  // Slot i is squashed when it lies on the circular walk paste_idx..youngest_idx.
  function automatic logic in_squash(input logic [IDX_W-1:0] i,
                                     input logic [IDX_W-1:0] p,
                                     input logic [IDX_W-1:0] y);
    logic [IDX_W-1:0] off;
    logic [IDX_W-1:0] span;
    off  = i - p;
    span = y - p;
    return off <= span;
  endfunction

  always_comb begin
    squash_mask = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      squash_mask[i] = in_squash(IDX_W'(i), paste_idx, youngest_q);
    end
  end

  // A copy issued alongside any paste belongs to the squashed path and is dropped.
  assign paste_ok = paste_rat && !flush && valid_q[paste_idx];
  assign copy_ok  = copy_rat && !flush && !paste_rat;

  always_comb begin
    valid_d         = valid_q;
    youngest_d      = youngest_q;
    restore_map_d   = restore_map_q;
    restore_valid_d = 1'b0;
    restore_err_d   = 1'b0;
    overwrite_d     = 1'b0;
`ifdef CKPT_FREELIST_EN
    restore_fl_d    = restore_fl_q;
`endif
    if (flush) begin
      valid_d = '0;
    end else begin
      if (release_rat) begin
        valid_d[release_idx] = 1'b0;
      end
      if (copy_ok) begin
        valid_d[copy_idx] = 1'b1;
        youngest_d        = copy_idx;
        overwrite_d       = valid_q[copy_idx];
      end
      if (paste_rat) begin
        if (paste_ok) begin
          valid_d         = valid_d & ~squash_mask;
          youngest_d      = paste_idx - IDX_W'(1);
          restore_valid_d = 1'b1;
          restore_map_d   = slot_q[paste_idx];
`ifdef CKPT_FREELIST_EN
          restore_fl_d    = fl_q[paste_idx];
`endif
        end else begin
          restore_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= '0;
      youngest_q      <= '0;
      restore_map_q   <= '0;
      restore_valid_q <= 1'b0;
      restore_err_q   <= 1'b0;
      overwrite_q     <= 1'b0;
`ifdef CKPT_FREELIST_EN
      restore_fl_q    <= '0;
`endif
    end else begin
      valid_q         <= valid_d;
      youngest_q      <= youngest_d;
      restore_map_q   <= restore_map_d;
      restore_valid_q <= restore_valid_d;
      restore_err_q   <= restore_err_d;
      overwrite_q     <= overwrite_d;
`ifdef CKPT_FREELIST_EN
      restore_fl_q    <= restore_fl_d;
`endif
    end
  end

  // Snapshot storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst && copy_ok) begin
      slot_q[copy_idx] <= rat_map_in;
`ifdef CKPT_FREELIST_EN
      fl_q[copy_idx]   <= fl_head_in;
`endif
    end
  end

  assign restore_valid  = restore_valid_q;
  assign restore_map    = restore_map_q;
  assign restore_err    = restore_err_q;
  assign ckpt_overwrite = overwrite_q;
  assign ckpt_valid     = valid_q;
  assign youngest_idx   = youngest_q;
`ifdef CKPT_FREELIST_EN
  assign restore_fl_head = restore_fl_q;
`endif

endmodule

// File: tb/tb_rat_checkpoint_store.sv
// Directed self-checking bench for rat_checkpoint_store.
module tb_rat_checkpoint_store;

  localparam int NUM_ARCH = 32;
  localparam int PTAG_W   = 6;
  localparam int NUM_CKPT = 32;
  localparam int IDX_W    = 5;
  localparam int MAP_W    = NUM_ARCH * PTAG_W;

  logic                clk;
  logic                rst;
  logic                flush;
  logic                copy_rat;
  logic [IDX_W-1:0]    copy_idx;
  logic [MAP_W-1:0]    rat_map_in;
  logic                paste_rat;
  logic [IDX_W-1:0]    paste_idx;
  logic                release_rat;
  logic [IDX_W-1:0]    release_idx;
  logic                restore_valid;
  logic [MAP_W-1:0]    restore_map;
  logic                restore_err;
  logic                ckpt_overwrite;
  logic [NUM_CKPT-1:0] ckpt_valid;
  logic [IDX_W-1:0]    youngest_idx;
`ifdef CKPT_FREELIST_EN
  logic [5:0]          fl_head_in;
  logic [5:0]          restore_fl_head;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  rat_checkpoint_store dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .copy_rat       (copy_rat),
    .copy_idx       (copy_idx),
    .rat_map_in     (rat_map_in),
    .paste_rat      (paste_rat),
    .paste_idx      (paste_idx),
    .release_rat    (release_rat),
    .release_idx    (release_idx),
`ifdef CKPT_FREELIST_EN
    .fl_head_in     (fl_head_in),
    .restore_fl_head(restore_fl_head),
`endif
    .restore_valid  (restore_valid),
    .restore_map    (restore_map),
    .restore_err    (restore_err),
    .ckpt_overwrite (ckpt_overwrite),
    .ckpt_valid     (ckpt_valid),
    .youngest_idx   (youngest_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [MAP_W-1:0] rep(input logic [PTAG_W-1:0] v);
    return {NUM_ARCH{v}};
  endfunction

  task automatic idle();
    flush       = 1'b0;
    copy_rat    = 1'b0;
    paste_rat   = 1'b0;
    release_rat = 1'b0;
  endtask

  // Advance one clock; outputs are examined 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_copy(input logic [IDX_W-1:0] idx, input logic [MAP_W-1:0] m);
    copy_rat   = 1'b1;
    copy_idx   = idx;
    rat_map_in = m;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    cmp_cnt++; if (ckpt_valid !== 32'h0) begin err_cnt++; $display("FAIL reset_valid got %h exp %h", ckpt_valid, 32'h0); end
    cmp_cnt++; if (youngest_idx !== 5'd0) begin err_cnt++; $display("FAIL reset_youngest got %0d exp 0", youngest_idx); end
    cmp_cnt++; if ({restore_valid, restore_err, ckpt_overwrite} !== 3'b000) begin err_cnt++; $display("FAIL reset_pulses got %b exp 000", {restore_valid, restore_err, ckpt_overwrite}); end
    cmp_cnt++; if (restore_map !== '0) begin err_cnt++; $display("FAIL reset_map got %h exp 0", restore_map); end
  endtask

  task automatic test_basic();
    do_copy(5'd3, rep(6'h05));
    cmp_cnt++; if (ckpt_valid !== 32'h0000_0008) begin err_cnt++; $display("FAIL basic_copy_valid got %h exp %h", ckpt_valid, 32'h8); end
    cmp_cnt++; if (youngest_idx !== 5'd3) begin err_cnt++; $display("FAIL basic_youngest got %0d exp 3", youngest_idx); end
    paste_rat = 1'b1; paste_idx = 5'd3;
    tick();
    cmp_cnt++; if (restore_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_rv got %b exp 1", restore_valid); end
    cmp_cnt++; if (restore_map !== rep(6'h05)) begin err_cnt++; $display("FAIL basic_map got %h exp %h", restore_map, rep(6'h05)); end
    cmp_cnt++; if (ckpt_valid !== 32'h0) begin err_cnt++; $display("FAIL basic_squash got %h exp 0", ckpt_valid); end
    cmp_cnt++; if (youngest_idx !== 5'd2) begin err_cnt++; $display("FAIL basic_youngest_after got %0d exp 2", youngest_idx); end
    tick();
    cmp_cnt++; if (restore_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_rv_pulse got %b exp 0", restore_valid); end
    cmp_cnt++; if (restore_map !== rep(6'h05)) begin err_cnt++; $display("FAIL basic_map_hold got %h exp %h", restore_map, rep(6'h05)); end
  endtask

  task automatic test_wrap();
    do_copy(5'd30, rep(6'h1E));
    do_copy(5'd31, rep(6'h1F));
    do_copy(5'd0,  rep(6'h20));
    do_copy(5'd1,  rep(6'h21));
    cmp_cnt++; if (ckpt_valid !== 32'hC000_0003) begin err_cnt++; $display("FAIL wrap_valid got %h exp %h", ckpt_valid, 32'hC000_0003); end
    cmp_cnt++; if (youngest_idx !== 5'd1) begin err_cnt++; $display("FAIL wrap_youngest got %0d exp 1", youngest_idx); end
    paste_rat = 1'b1; paste_idx = 5'd31;
    tick();
    cmp_cnt++; if (ckpt_valid !== 32'h4000_0000) begin err_cnt++; $display("FAIL wrap_squash got %h exp %h", ckpt_valid, 32'h4000_0000); end
    cmp_cnt++; if (youngest_idx !== 5'd30) begin err_cnt++; $display("FAIL wrap_youngest_after got %0d exp 30", youngest_idx); end
    cmp_cnt++; if (restore_map !== rep(6'h1F)) begin err_cnt++; $display("FAIL wrap_map got %h exp %h", restore_map, rep(6'h1F)); end
  endtask

  task automatic test_invalid_paste();
    paste_rat = 1'b1; paste_idx = 5'd7;
    tick();
    cmp_cnt++; if ({restore_err, restore_valid} !== 2'b10) begin err_cnt++; $display("FAIL inv_pulses got %b exp 10", {restore_err, restore_valid}); end
    cmp_cnt++; if (ckpt_valid !== 32'h4000_0000) begin err_cnt++; $display("FAIL inv_valid got %h exp %h", ckpt_valid, 32'h4000_0000); end
    cmp_cnt++; if (youngest_idx !== 5'd30) begin err_cnt++; $display("FAIL inv_youngest got %0d exp 30", youngest_idx); end
    tick();
    cmp_cnt++; if (restore_err !== 1'b0) begin err_cnt++; $display("FAIL inv_err_pulse got %b exp 0", restore_err); end
  endtask

  task automatic test_copy_paste();
    do_copy(5'd4, rep(6'h04));
    copy_rat = 1'b1; copy_idx = 5'd5; rat_map_in = rep(6'h2A);
    paste_rat = 1'b1; paste_idx = 5'd4;
    tick();
    cmp_cnt++; if (restore_valid !== 1'b1) begin err_cnt++; $display("FAIL cp_rv got %b exp 1", restore_valid); end
    cmp_cnt++; if (restore_map !== rep(6'h04)) begin err_cnt++; $display("FAIL cp_map got %h exp %h", restore_map, rep(6'h04)); end
    cmp_cnt++; if (ckpt_valid !== 32'h4000_0000) begin err_cnt++; $display("FAIL cp_valid got %h exp %h", ckpt_valid, 32'h4000_0000); end
    cmp_cnt++; if (youngest_idx !== 5'd3) begin err_cnt++; $display("FAIL cp_youngest got %0d exp 3", youngest_idx); end
    cmp_cnt++; if (ckpt_overwrite !== 1'b0) begin err_cnt++; $display("FAIL cp_ovw got %b exp 0", ckpt_overwrite); end
  endtask

  task automatic test_flush();
    do_copy(5'd2, rep(6'h02));
    do_copy(5'd3, rep(6'h03));
    do_copy(5'd4, rep(6'h04));
    cmp_cnt++; if (ckpt_valid !== 32'h4000_001C) begin err_cnt++; $display("FAIL flush_pre got %h exp %h", ckpt_valid, 32'h4000_001C); end
    flush = 1'b1; paste_rat = 1'b1; paste_idx = 5'd2;
    tick();
    cmp_cnt++; if (ckpt_valid !== 32'h0) begin err_cnt++; $display("FAIL flush_valid got %h exp 0", ckpt_valid); end
    cmp_cnt++; if ({restore_valid, restore_err} !== 2'b00) begin err_cnt++; $display("FAIL flush_pulses got %b exp 00", {restore_valid, restore_err}); end
  endtask

  task automatic test_overwrite();
    do_copy(5'd9, rep(6'h11));
    cmp_cnt++; if (ckpt_overwrite !== 1'b0) begin err_cnt++; $display("FAIL ovw_first got %b exp 0", ckpt_overwrite); end
    do_copy(5'd9, rep(6'h22));
    cmp_cnt++; if (ckpt_overwrite !== 1'b1) begin err_cnt++; $display("FAIL ovw_second got %b exp 1", ckpt_overwrite); end
    tick();
    cmp_cnt++; if (ckpt_overwrite !== 1'b0) begin err_cnt++; $display("FAIL ovw_pulse got %b exp 0", ckpt_overwrite); end
    paste_rat = 1'b1; paste_idx = 5'd9;
    tick();
    cmp_cnt++; if (restore_map !== rep(6'h22)) begin err_cnt++; $display("FAIL ovw_map got %h exp %h", restore_map, rep(6'h22)); end
    cmp_cnt++; if (ckpt_valid !== 32'h0) begin err_cnt++; $display("FAIL ovw_valid got %h exp 0", ckpt_valid); end
  endtask

  task automatic test_back_to_back();
    do_copy(5'd10, rep(6'h0A));
    do_copy(5'd11, rep(6'h0B));
    release_rat = 1'b1; release_idx = 5'd10;
    tick();
    cmp_cnt++; if (ckpt_valid !== 32'h0000_0800) begin err_cnt++; $display("FAIL rel_valid got %h exp %h", ckpt_valid, 32'h800); end
    cmp_cnt++; if (youngest_idx !== 5'd11) begin err_cnt++; $display("FAIL rel_youngest got %0d exp 11", youngest_idx); end
    release_rat = 1'b1; release_idx = 5'd12;
    copy_rat = 1'b1; copy_idx = 5'd12; rat_map_in = rep(6'h0C);
    tick();
    cmp_cnt++; if (ckpt_valid !== 32'h0000_1800) begin err_cnt++; $display("FAIL relcopy_valid got %h exp %h", ckpt_valid, 32'h1800); end
    paste_rat = 1'b1; paste_idx = 5'd12;
    tick();
    cmp_cnt++; if (restore_map !== rep(6'h0C)) begin err_cnt++; $display("FAIL b2b_map1 got %h exp %h", restore_map, rep(6'h0C)); end
    cmp_cnt++; if (youngest_idx !== 5'd11) begin err_cnt++; $display("FAIL b2b_youngest1 got %0d exp 11", youngest_idx); end
    paste_rat = 1'b1; paste_idx = 5'd11;
    tick();
    cmp_cnt++; if ({restore_valid, restore_err} !== 2'b10) begin err_cnt++; $display("FAIL b2b_pulses got %b exp 10", {restore_valid, restore_err}); end
    cmp_cnt++; if (restore_map !== rep(6'h0B)) begin err_cnt++; $display("FAIL b2b_map2 got %h exp %h", restore_map, rep(6'h0B)); end
    cmp_cnt++; if (ckpt_valid !== 32'h0) begin err_cnt++; $display("FAIL b2b_valid got %h exp 0", ckpt_valid); end
    cmp_cnt++; if (youngest_idx !== 5'd10) begin err_cnt++; $display("FAIL b2b_youngest2 got %0d exp 10", youngest_idx); end
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    copy_rat    = 1'b0;
    copy_idx    = '0;
    rat_map_in  = '0;
    paste_rat   = 1'b0;
    paste_idx   = '0;
    release_rat = 1'b0;
    release_idx = '0;
`ifdef CKPT_FREELIST_EN
    fl_head_in  = '0;
`endif
    test_reset();
    test_basic();
    test_wrap();
    test_invalid_paste();
    test_copy_paste();
    test_flush();
    test_overwrite();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
